i2c_master_write_byte: RTL and testbench

//  Byte-transmit stage of the I2C master. Runs directly after the start/restart stage, which leaves SCL low.
//  - Shifts one byte MSB-first onto the bus.
//  - Clocks a 9th bit and samples the slave ACK.
//  - Honours clock stretching with a timeout.
//  - Reports completion to the transaction controller.

---
 rtl/i2c_master_pkg.sv | 16 +
 rtl/i2c_line_sync.sv | 28 ++
 rtl/i2c_master_write_byte.sv | 142 ++++++++++++++
 tb/tb_i2c_master_write_byte.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master stages (start/restart, write-byte,
// read-byte, stop): write-byte FSM states, open-drain line levels and
// default bus timing.
package i2c_master_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, RELEASE, HIGH, DONE} write_byte_state_t;

  // Open-drain levels: a line is either pulled to 0 or let go.
  localparam logic DRIVE_LOW     = 1'b0;
  localparam logic DRIVE_RELEASE = 1'bz;

  // 50 MHz system clock -> 100 kHz SCL.
  localparam int QUARTER_CYCLES_DEFAULT     = 125;
  localparam int MAX_STRETCH_CYCLES_DEFAULT = 5000;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for the SDA and SCL bus lines.
// Ports: clock, reset (sync, active-high), sda_in/scl_in raw lines,
//        sda_sync/scl_sync synchronized copies (reset to the idle-high level).
module i2c_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic sda_in,
  input  logic scl_in,
  output logic sda_sync,
  output logic scl_sync
);

  logic [1:0] sda_pipe, scl_pipe;

  always_ff @(posedge clock) begin
    if (reset) begin
      sda_pipe <= 2'b11;
      scl_pipe <= 2'b11;
    end else begin
      sda_pipe <= {sda_pipe[0], sda_in};
      scl_pipe <= {scl_pipe[0], scl_in};
    end
  end

  assign sda_sync = sda_pipe[1];
  assign scl_sync = scl_pipe[1];

endmodule

// File: rtl/i2c_master_write_byte.sv
// I2C master byte-transmit stage. Entered with SCL low (left there by the
// start/restart stage); shifts a byte MSB-first, clocks a 9th bit to sample
// the slave ACK, honours clock stretching with a timeout, and leaves SCL
// low for the following stop/restart stage.
// Ports: clock, reset (sync, active-high); start/data request (accepted when
//        !busy); busy, done pulse, ack_received, clock_stretch_timeout status;
//        sda/scl open-drain bus lines.
module i2c_master_write_byte
  import i2c_master_pkg::*;
#(
  parameter int QUARTER_CYCLES     = QUARTER_CYCLES_DEFAULT,
  parameter int MAX_STRETCH_CYCLES = MAX_STRETCH_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_received,
  output logic       clock_stretch_timeout,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int QW = (2*QUARTER_CYCLES > 1) ? $clog2(2*QUARTER_CYCLES) : 1;
  localparam int SW = $clog2(MAX_STRETCH_CYCLES+1);
  localparam logic [QW-1:0] Q_LOAD = QW'(2*QUARTER_CYCLES-1);
  localparam logic [QW-1:0] Q_MID  = QW'(QUARTER_CYCLES-1);
  localparam logic [SW-1:0] S_LAST = SW'(MAX_STRETCH_CYCLES-1);
  localparam logic [SW-1:0] S_MAX  = SW'(MAX_STRETCH_CYCLES);

  write_byte_state_t state, state_nx;

  logic [QW-1:0] qcnt;
  logic [SW-1:0] scnt;
  logic [7:0]    shreg;
  logic [3:0]    bitcnt;
  logic          sda_low;
  logic          sda_sync, scl_sync;

  logic accept, q_zero, stretch_last;
  logic scl_low, done_nx, timeout_ev, ack_sample, bit_tick;

  i2c_line_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .sda_in   (sda),
    .scl_in   (scl),
    .sda_sync (sda_sync),
    .scl_sync (scl_sync)
  );

  assign accept       = start && !busy;
  assign q_zero       = (qcnt == '0);
  assign stretch_last = (scnt == S_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   if (q_zero) state_nx = RELEASE;
      // A high SCL wins over a timeout landing in the same cycle.
      RELEASE: if (scl_sync)          state_nx = HIGH;
               else if (stretch_last) state_nx = IDLE;
      HIGH:    if (q_zero) state_nx = (bitcnt == 4'd1) ? DONE : SETUP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs / per-state strobes
  always_comb begin
    scl_low    = (state == SETUP) || (state == DONE);
    timeout_ev = (state == RELEASE) && !scl_sync && stretch_last;
    done_nx    = (state == DONE) || timeout_ev;
    // ACK is sampled mid-way through the 9th high phase.
    ack_sample = (state == HIGH) && (bitcnt == 4'd1) && (qcnt == Q_MID);
    // SDA moves a quarter period into the low phase, well clear of both SCL edges.
    bit_tick   = (state == SETUP) && (qcnt == Q_MID);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy                  <= 1'b0;
      done                  <= 1'b0;
      ack_received          <= 1'b0;
      clock_stretch_timeout <= 1'b0;
      sda_low               <= 1'b0;
      qcnt                  <= '0;
      scnt                  <= '0;
      shreg                 <= '0;
      bitcnt                <= '0;
    end else begin
      done <= done_nx;

      // busy spans the done cycle so a start coinciding with done is dropped.
      if (accept) begin
        busy                  <= 1'b1;
        shreg                 <= data;
        bitcnt                <= 4'd9;
        ack_received          <= 1'b0;
        clock_stretch_timeout <= 1'b0;
      end else if (done) begin
        busy <= 1'b0;
      end

      if (state_nx != state) qcnt <= Q_LOAD;
      else if (!q_zero)      qcnt <= qcnt - QW'(1);

      if (state != RELEASE)  scnt <= '0;
      else if (scnt != S_MAX) scnt <= scnt + SW'(1);

      // Bit 9 (bitcnt==1) lets SDA go for the slave's ACK.
      if (bit_tick)               sda_low <= (bitcnt != 4'd1) && !shreg[7];
      else if (state_nx == IDLE)  sda_low <= 1'b0;

      if ((state == HIGH) && q_zero) begin
        bitcnt <= bitcnt - 4'd1;
        shreg  <= {shreg[6:0], 1'b0};
      end

      if (ack_sample) ack_received <= ~sda_sync;

      if (timeout_ev) begin
        clock_stretch_timeout <= 1'b1;
        ack_received          <= 1'b0;
      end
    end
  end

  assign scl = scl_low ? DRIVE_LOW : DRIVE_RELEASE;
  assign sda = sda_low ? DRIVE_LOW : DRIVE_RELEASE;

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// Bench for i2c_master_write_byte: pulled-up bus with a slave model that
// ACKs/NACKs and stretches SCL; expectations from a cycle-budget model,
// checked by a done-driven monitor against a scoreboard queue.
module tb_i2c_master_write_byte;

  localparam int Q    = 2;
  localparam int MAXS = 20;
  localparam int PER  = 4*Q + 3;   // cycles per bit with no stretch

  logic       clock = 1'b0;
  logic       reset, start;
  logic [7:0] data;
  logic       busy, done, ack_received, clock_stretch_timeout;
  wire        sda, scl;

  pullup (sda);
  pullup (scl);

  i2c_master_write_byte #(.QUARTER_CYCLES(Q), .MAX_STRETCH_CYCLES(MAXS)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .data                  (data),
    .busy                  (busy),
    .done                  (done),
    .ack_received          (ack_received),
    .clock_stretch_timeout (clock_stretch_timeout),
    .sda                   (sda),
    .scl                   (scl)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  logic s_sda = 1'b0, s_scl = 1'b0;
  assign sda = s_sda ? 1'b0 : 1'bz;
  assign scl = s_scl ? 1'b0 : 1'bz;

  bit slv_rst = 0, cfg_ack = 0, cfg_forever = 0;
  int cfg_sbit = 0, cfg_slen = 0;
  int falls = 0, hold = 0;
  logic scl_prev = 1'b1;

  // Falling edge k opens the low phase of bit k; edge 10 ends bit 9.
  always @(negedge clock) begin
    if (slv_rst || reset) begin
      falls = 0; s_sda = 1'b0; s_scl = 1'b0; hold = 0;
    end else if (scl_prev && !scl) begin
      falls++;
      if (falls == 9 && cfg_ack) s_sda = 1'b1;
      if (falls == 10) s_sda = 1'b0;
      if (falls == cfg_sbit) begin
        s_scl = 1'b1;
        hold  = 2*Q + cfg_slen;
      end
    end else if (s_scl && !cfg_forever) begin
      hold--;
      if (hold <= 0) s_scl = 1'b0;
    end
    scl_prev = scl;
  end

  // ---------------- bus sampler ----------------
  typedef struct { int c; logic v; } cap_t;
  cap_t cap[$];
  bit   chk_en = 0, pv = 0;
  logic p_sda, p_scl;

  always begin
    @(clock);
    #2;
    if (pv) begin
      if (chk_en && (sda !== p_sda)) chk("sda_moved_with_scl_high", int'(p_scl | scl), 0);
      if (!p_scl && scl) cap.push_back('{cyc, sda});
    end
    p_sda = sda; p_scl = scl; pv = 1;
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct { int acc; int lat; bit ack; bit to; logic [7:0] d; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   nb;
  logic [8:0] bits;

  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("ack_received", int'(ack_received), int'(e.ack));
        chk("stretch_timeout", int'(clock_stretch_timeout), int'(e.to));
        if (!e.to) begin
          nb = 0; bits = '0;
          foreach (cap[i]) if (cap[i].c >= e.acc && nb < 9) begin
            bits[8-nb] = cap[i].v; nb++;
          end
          chk("bits_clocked", nb, 9);
          chk("byte_on_bus", int'(bits[8:1]), int'(e.d));
          chk("ack_bit_on_bus", int'(bits[0]), int'(!e.ack));
        end
      end
      cap.delete();
    end
  end

  // ---------------- reference model ----------------
  // Stretch on bit sbit adds slen cycles to its release phase; a slave that
  // never lets go aborts MAXS cycles into that bit's release phase.
  function automatic void model(input bit ack, input int sbit, input int slen, input bit forever_h,
                                output int lat, output bit ea, output bit et);
    if (forever_h) begin
      lat = (sbit-1)*PER + 2*Q + MAXS; ea = 0; et = 1;
    end else begin
      lat = 9*PER + 1 + ((sbit != 0) ? slen : 0); ea = ack; et = 0;
    end
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clock); #1; end
  endtask

  task automatic issue(input logic [7:0] d, input bit ack, input int sbit, input int slen,
                       input bit forever_h, output int acc, output int lat, output bit ea, output bit et);
    exp_t x;
    model(ack, sbit, slen, forever_h, lat, ea, et);
    cfg_ack = ack; cfg_sbit = sbit; cfg_slen = slen; cfg_forever = forever_h;
    @(posedge clock); #1;
    start = 1'b1; data = d; slv_rst = 1;
    acc = cyc + 1;
    x = '{acc, lat, ea, et, d};
    sb.push_back(x);
    @(posedge clock); #1;
    start = 1'b0; slv_rst = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin @(posedge clock); n++; end
    if (sb.size() != 0) begin
      chk({name, "_done_wait_expired"}, n, 0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [7:0] d, input bit ack, input int sbit, input int slen,
                     input bit forever_h, input int inj);
    int acc, lat; bit ea, et;
    issue(d, ack, sbit, slen, forever_h, acc, lat, ea, et);
    if (inj != 0) begin
      wait_cyc(acc + inj);
      start = 1'b1; data = 8'hFF;
      @(posedge clock); #1;
      start = 1'b0;
    end
    wait_drain("xfer");
    repeat (3) @(negedge clock);
    chk("ack_held", int'(ack_received), int'(ea));
    chk("timeout_held", int'(clock_stretch_timeout), int'(et));
    chk("busy_idle", int'(busy), 0);
    if (forever_h) begin
      chk("sda_released_after_timeout", int'(sda), 1);
      slv_rst = 1;
      repeat (2) @(negedge clock);
      slv_rst = 0;
      chk("scl_released_after_timeout", int'(scl), 1);
    end
    repeat ($urandom_range(5, 2)) @(posedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int acc, lat;
  bit ea, et;

  initial begin
    reset = 1'b1; start = 1'b0; data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack", int'(ack_received), 0);
    chk("rst_timeout", int'(clock_stretch_timeout), 0);
    chk("rst_sda", int'(sda), 1);
    chk("rst_scl", int'(scl), 1);
    chk_en = 1;

    run(8'hA5, 1, 0, 0, 0, 0);   // plain byte, ACK
    run(8'h3C, 0, 0, 0, 0, 0);   // NACK
    run(8'h96, 1, 4, 10, 0, 0);  // 10-cycle stretch on bit 4
    run(8'h12, 1, 2, 0, 1, 0);   // SCL held forever on bit 2
    run(8'h69, 1, 9, 17, 0, 0);  // longest stretch that still completes

    // Reset during bit 5's high phase.
    issue(8'hE7, 1, 0, 0, 0, acc, lat, ea, et);
    wait_cyc(acc + 4*PER + 2*Q + 4);
    chk_en = 0; reset = 1'b1; sb.delete();
    @(posedge clock);
    @(negedge clock);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_sda", int'(sda), 1);
    chk("midreset_scl", int'(scl), 1);
    chk("midreset_done", int'(done), 0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1 chk_en = 1;
    run(8'hE7, 1, 0, 0, 0, 0);

    // Second start mid-transfer must be ignored.
    run(8'h5B, 1, 0, 0, 0, 30);

    // Start in the done cycle must be ignored.
    issue(8'hC3, 0, 0, 0, 0, acc, lat, ea, et);
    wait_cyc(acc + lat);
    start = 1'b1; data = 8'h00;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("busy_after_start_on_done", int'(busy), 0);
    wait_drain("start_on_done");
    repeat (110) @(posedge clock);

    for (int i = 0; i < 10; i++) begin
      run(8'($urandom), 1'($urandom_range(1, 0)), $urandom_range(9, 0), $urandom_range(12, 0), 0,
          ($urandom_range(1, 0) != 0) ? $urandom_range(90, 5) : 0);
    end

    repeat (20) @(posedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
